// File: rtl/sum_accum_4b.sv
// Frame accumulator fed by the 4-bit adder; sums N_SAMPLES handshaked words.
// Optional macro ACC_SAT_EN: clamp the total at all-ones instead of wrapping.
module sum_accum_4b #(
    parameter int WIDTH     = 4,
    parameter int N_SAMPLES = 4,
    parameter int ACC_W     = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH:0]   i_sum,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_clear,
    output logic [ACC_W-1:0] o_acc,
    output logic             o_ovf,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [7:0]       o_count
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic [ACC_W:0]   sum_wide;
    logic             accept;

    assign o_ready = (state_q != HOLD);
    assign accept  = i_valid & o_ready;
    assign o_acc   = acc_q;
    assign o_ovf   = ovf_q;
    assign o_valid = valid_q;
    assign o_count = cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        valid_d  = valid_q;
        sum_wide = {1'b0, acc_q} + (ACC_W+1)'(i_sum);

        if (i_clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_d = ACC_W'(i_sum);
                        cnt_d = 8'd1;
                        ovf_d = 1'b0;
                        if (N_SAMPLES == 1) begin
                            state_d = HOLD;
                            valid_d = 1'b1;
                        end else begin
                            state_d = ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        cnt_d = cnt_q + 8'd1;
                        if (sum_wide[ACC_W])
                            ovf_d = 1'b1;
`ifdef ACC_SAT_EN
                        // once clamped, the total stays pinned for the frame
                        if (ovf_q || sum_wide[ACC_W])
                            acc_d = '1;
                        else
                            acc_d = sum_wide[ACC_W-1:0];
`else
                        acc_d = sum_wide[ACC_W-1:0];
`endif
                        if (cnt_d == 8'(N_SAMPLES)) begin
                            state_d = HOLD;
                            valid_d = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (i_ready) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

endmodule
